stroke_raster: RTL and testbench

STROKE_RASTER -- requirements
Module: stroke_raster

---
 rtl/stroke_raster_pkg.sv | 22 ++
 rtl/stroke_raster_if.sv | 27 ++
 rtl/stroke_raster.sv | 179 +++++++++++++++++
 tb/tb_stroke_raster.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stroke_raster_pkg.sv
// Shared definitions for the stroke rasterizer: coordinate width, color codes, FSM states.
package stroke_raster_pkg;
  localparam int COORD_W = 8;
  localparam int COLOR_W = 3;

  typedef enum logic [COLOR_W-1:0] {
    COLOR_BLACK  = 3'd0,
    COLOR_RED    = 3'd1,
    COLOR_GREEN  = 3'd2,
    COLOR_BLUE   = 3'd3,
    COLOR_YELLOW = 3'd4,
    COLOR_CYAN   = 3'd5,
    COLOR_PINK   = 3'd6,
    COLOR_WHITE  = 3'd7
  } color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;
endpackage

// File: rtl/stroke_raster_if.sv
// Brush-sample input handshake and pixel-store write handshake of the rasterizer.
interface stroke_raster_if #(parameter int COORD_W = stroke_raster_pkg::COORD_W);
  import stroke_raster_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               in_pen;
  logic [COLOR_W-1:0] in_color;
  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               busy;

  modport slave (
    input  in_valid, in_x, in_y, in_pen, in_color, wr_ready,
    output in_ready, wr_valid, wr_x, wr_y, wr_color, busy
  );

  modport master (
    output in_valid, in_x, in_y, in_pen, in_color, wr_ready,
    input  in_ready, wr_valid, wr_x, wr_y, wr_color, busy
  );
endinterface

// File: rtl/stroke_raster.sv
// Bresenham segment rasterizer joining consecutive pen-down brush samples.
// state | meaning
// IDLE  | waiting for a brush sample, in_ready high
// SETUP | classify sample, load segment deltas, prepare first pixel
// DRAW  | offer pixels, step once per completed write handshake
module stroke_raster
  import stroke_raster_pkg::*;
#(
  parameter int COORD_W = stroke_raster_pkg::COORD_W
) (
  input  logic          clk,
  input  logic          reset,
  stroke_raster_if.slave bus
);
  localparam int EW = COORD_W + 2;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic signed [EW-1:0] err_t;
  typedef struct packed {
    coord_t x;
    coord_t y;
    err_t   err;
  } step_t;

  // One Bresenham step; e2 is one bit wider than err so 2*err never overflows.
  function automatic step_t bres_step(input coord_t x, input coord_t y, input err_t err,
                                      input coord_t dx, input coord_t dy,
                                      input logic sx_neg, input logic sy_neg);
    logic signed [EW:0] e2;
    logic signed [EW:0] dx_w;
    logic signed [EW:0] dy_w;
    step_t s;
    e2    = {err, 1'b0};
    dx_w  = {3'b000, dx};
    dy_w  = {3'b000, dy};
    s.x   = x;
    s.y   = y;
    s.err = err;
    if (e2 > -dy_w) begin
      s.err = s.err - err_t'({2'b00, dy});
      s.x   = sx_neg ? x - 1'b1 : x + 1'b1;
    end
    if (e2 < dx_w) begin
      s.err = s.err + err_t'({2'b00, dx});
      s.y   = sy_neg ? y - 1'b1 : y + 1'b1;
    end
    return s;
  endfunction

  state_t             state;
  coord_t             last_x, last_y;
  logic               last_valid;
  coord_t             org_x, org_y, tgt_x, tgt_y;
  logic               org_valid;
  logic               pen_r;
  logic [COLOR_W-1:0] color_r;
  coord_t             dx_r, dy_r;
  logic               sx_r, sy_r;
  err_t               err_r;
  logic               in_ready_r, busy_r, wr_valid_r;
  coord_t             wr_x_r, wr_y_r;
  logic [COLOR_W-1:0] wr_color_r;

  coord_t dx_c, dy_c;
  logic   sx_c, sy_c;
  err_t   err0_c;
  step_t  first_c, next_c;

  always_comb begin
    sx_c    = tgt_x < org_x;
    sy_c    = tgt_y < org_y;
    dx_c    = sx_c ? org_x - tgt_x : tgt_x - org_x;
    dy_c    = sy_c ? org_y - tgt_y : tgt_y - org_y;
    err0_c  = err_t'({2'b00, dx_c}) - err_t'({2'b00, dy_c});
    first_c = bres_step(org_x, org_y, err0_c, dx_c, dy_c, sx_c, sy_c);
    next_c  = bres_step(wr_x_r, wr_y_r, err_r, dx_r, dy_r, sx_r, sy_r);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_x     <= '0;
      last_y     <= '0;
      last_valid <= 1'b0;
      org_x      <= '0;
      org_y      <= '0;
      tgt_x      <= '0;
      tgt_y      <= '0;
      org_valid  <= 1'b0;
      pen_r      <= 1'b0;
      color_r    <= '0;
      dx_r       <= '0;
      dy_r       <= '0;
      sx_r       <= 1'b0;
      sy_r       <= 1'b0;
      err_r      <= '0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      wr_valid_r <= 1'b0;
      wr_x_r     <= '0;
      wr_y_r     <= '0;
      wr_color_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          if (bus.in_valid && in_ready_r) begin
            tgt_x      <= bus.in_x;
            tgt_y      <= bus.in_y;
            org_x      <= last_x;
            org_y      <= last_y;
            org_valid  <= last_valid;
            pen_r      <= bus.in_pen;
            color_r    <= bus.in_color;
            last_x     <= bus.in_x;
            last_y     <= bus.in_y;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (!pen_r) begin
            last_valid <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end else if (!org_valid) begin
            last_valid <= 1'b1;
            wr_x_r     <= tgt_x;
            wr_y_r     <= tgt_y;
            wr_color_r <= color_r;
            wr_valid_r <= 1'b1;
            state      <= DRAW;
          end else if (dx_c == '0 && dy_c == '0) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end else begin
            // The start point was already plotted, so the first offer is one step in.
            dx_r       <= dx_c;
            dy_r       <= dy_c;
            sx_r       <= sx_c;
            sy_r       <= sy_c;
            err_r      <= first_c.err;
            wr_x_r     <= first_c.x;
            wr_y_r     <= first_c.y;
            wr_color_r <= color_r;
            wr_valid_r <= 1'b1;
            state      <= DRAW;
          end
        end
        DRAW: begin
          if (bus.wr_ready) begin
            if (wr_x_r == tgt_x && wr_y_r == tgt_y) begin
              wr_valid_r <= 1'b0;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b0;
              state      <= IDLE;
            end else begin
              wr_x_r <= next_c.x;
              wr_y_r <= next_c.y;
              err_r  <= next_c.err;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.busy     = busy_r;
  assign bus.wr_valid = wr_valid_r;
  assign bus.wr_x     = wr_x_r;
  assign bus.wr_y     = wr_y_r;
  assign bus.wr_color = wr_color_r;
endmodule

// File: tb/tb_stroke_raster.sv
// Bench for stroke_raster: directed table, stall/reset sequences and random strokes vs a line model.
module tb_stroke_raster;
  import stroke_raster_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    int x;
    int y;
    bit pen;
    int color;
    int exp_n;
    int exp_lx;
    int exp_ly;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  stroke_raster_if #(.COORD_W(8)) bus();
  stroke_raster #(.COORD_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int pidx = 0;
  int rise_cyc = -1;
  int stall_seen = 0;
  bit stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  pix_t got[$];
  pix_t exp_q[$];
  int m_lx = 0, m_ly = 0;
  bit m_lv = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.wr_ready = 1'b1;
        1: bus.wr_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.wr_valid) begin
            bus.wr_ready = stall_pat[pidx % 4];
            pidx++;
          end else bus.wr_ready = 1'b1;
        end
      endcase
    end
  end

  // Write-port monitor: captures handshakes and checks hold/ready rules.
  initial begin
    logic prev_valid, prev_stall;
    pix_t prev_pix, cur;
    prev_valid = 1'b0;
    prev_stall = 1'b0;
    prev_pix = '0;
    forever begin
      @(negedge clk);
      cur.x = bus.wr_x;
      cur.y = bus.wr_y;
      cur.c = bus.wr_color;
      if (reset) begin
        if (bus.wr_valid && !prev_valid) rise_cyc = cyc;
        if (prev_stall) begin
          checks++;
          stall_seen++;
          if (!bus.wr_valid || cur != prev_pix) begin
            failures++;
            $display("FAIL stall_hold actual=%b/%h required=1/%h", bus.wr_valid, cur, prev_pix);
          end
        end
        if (prev_valid && !bus.wr_valid) begin
          checks++;
          if (!bus.in_ready) begin
            failures++;
            $display("FAIL ready_after_last actual=%b required=1", bus.in_ready);
          end
        end
        if (bus.wr_valid && bus.wr_ready) got.push_back(cur);
        prev_stall = bus.wr_valid && !bus.wr_ready;
        prev_valid = bus.wr_valid;
        prev_pix   = cur;
      end else begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void push_pix(input int x, input int y, input int c);
    pix_t p;
    p.x = 8'(x);
    p.y = 8'(y);
    p.c = 3'(c);
    exp_q.push_back(p);
  endfunction

  // Reference: plain integer walk of the segment with the stated step rule.
  task automatic model(input int x, input int y, input bit pen, input int color);
    exp_q.delete();
    if (!pen) m_lv = 1'b0;
    else if (!m_lv) begin
      push_pix(x, y, color);
      m_lv = 1'b1;
    end else if (x != m_lx || y != m_ly) begin
      int cx, cy, dx, dy, sx, sy, err, e2;
      cx = m_lx;
      cy = m_ly;
      dx = (x > m_lx) ? x - m_lx : m_lx - x;
      dy = (y > m_ly) ? y - m_ly : m_ly - y;
      sx = (x >= m_lx) ? 1 : -1;
      sy = (y >= m_ly) ? 1 : -1;
      err = dx - dy;
      for (int k = 0; k < 600 && !(cx == x && cy == y); k++) begin
        e2 = 2 * err;
        if (e2 > -dy) begin
          err -= dy;
          cx += sx;
        end
        if (e2 < dx) begin
          err += dx;
          cy += sy;
        end
        push_pix(cx, cy, color);
      end
    end
    m_lx = x;
    m_ly = y;
  endtask

  task automatic send(input int x, input int y, input bit pen, input int color, output int acc);
    bit r;
    @(posedge clk);
    #1;
    bus.in_x = 8'(x);
    bus.in_y = 8'(y);
    bus.in_pen = pen;
    bus.in_color = 3'(color);
    bus.in_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.wr_valid) break;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=busy required=idle");
    end
  endtask

  task automatic apply(input string name, input int x, input int y, input bit pen, input int color);
    int acc, bad;
    got.delete();
    model(x, y, pen, color);
    rise_cyc = -1;
    send(x, y, pen, color, acc);
    drain();
    checks++;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] != exp_q[i] && bad < 0) bad = i;
    if (got.size() != exp_q.size() || bad >= 0) begin
      failures++;
      $display("FAIL %s_pixels actual_n=%0d required_n=%0d first_diff=%0d", name, got.size(), exp_q.size(), bad);
    end
    if (exp_q.size() > 0) chk({name, "_first_latency"}, rise_cyc - acc, 1);
  endtask

  vec_t tbl [11];

  initial begin
    int acc, n;
    tbl[0]  = '{10, 10, 1, 1, 1, 10, 10};
    tbl[1]  = '{14, 12, 1, 2, 4, 14, 12};
    tbl[2]  = '{14, 12, 1, 3, 0, 0, 0};
    tbl[3]  = '{60, 60, 0, 4, 0, 0, 0};
    tbl[4]  = '{70, 70, 1, 5, 1, 70, 70};
    tbl[5]  = '{70, 80, 1, 6, 10, 70, 80};
    tbl[6]  = '{60, 75, 1, 7, 10, 60, 75};
    tbl[7]  = '{0, 0, 1, 0, 75, 0, 0};
    tbl[8]  = '{255, 255, 1, 1, 255, 255, 255};
    tbl[9]  = '{7, 7, 1, 2, 248, 7, 7};
    tbl[10] = '{7, 7, 1, 3, 0, 0, 0};

    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_pen = 1'b0;
    bus.in_color = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_valid", int'(bus.wr_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_wr_x", int'(bus.wr_x), 0);
    chk("rst_wr_y", int'(bus.wr_y), 0);
    chk("rst_wr_color", int'(bus.wr_color), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_next", int'(bus.in_ready), 1);

    ready_mode = 0;
    foreach (tbl[i]) begin
      apply($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].pen, tbl[i].color);
      chk($sformatf("tbl%0d_count", i), got.size(), tbl[i].exp_n);
      if (tbl[i].exp_n > 0 && got.size() > 0) begin
        chk($sformatf("tbl%0d_last_x", i), int'(got[got.size()-1].x), tbl[i].exp_lx);
        chk($sformatf("tbl%0d_last_y", i), int'(got[got.size()-1].y), tbl[i].exp_ly);
      end
    end

    // Stalled segment: every pixel exactly once, outputs held through stalls.
    ready_mode = 2;
    pidx = 0;
    apply("stall_start", 20, 5, 1, 3);
    pidx = 0;
    stall_seen = 0;
    apply("stall_seg", 20, 9, 1, 4);
    chk("stall_seen", int'(stall_seen > 0), 1);

    // Reset in the middle of a long vertical segment.
    ready_mode = 0;
    apply("rst_seg_start", 0, 0, 1, 5);
    got.delete();
    send(0, 100, 1, 6, acc);
    for (n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      if (bus.wr_valid && bus.wr_y == 8'd3) break;
    end
    chk("rst_mid_reached", int'(n < 500), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_wr_valid", int'(bus.wr_valid), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_writes_before", got.size(), 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    got.delete();
    repeat (20) @(negedge clk);
    chk("rst_mid_no_more_writes", got.size(), 0);
    m_lv = 1'b0;
    m_lx = 0;
    m_ly = 0;
    apply("after_reset", 40, 40, 1, 7);
    chk("after_reset_count", got.size(), 1);

    // Random strokes with a randomly stalling pixel store.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int rx, ry, rc;
      bit rp;
      rx = $urandom_range(0, 255);
      ry = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) begin
        rx = m_lx;
        ry = m_ly;
      end
      rp = ($urandom_range(0, 9) < 8);
      rc = $urandom_range(0, 7);
      apply($sformatf("rand%0d", i), rx, ry, rp, rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
